riscv_core_wb_arb: RTL and testbench

Write-back arbiter for the single register-file write port (we3/a3/wd3). It shares that port between NUM_REQ result producers: 0 = integer pipeline, 1 = MUL/DIV unit, 2 = LSU/AMO. Each producer uses a valid/ready handshake. The block selects one winner per cycle and drives the RF write port from registered outputs. The RF commits on the falling edge of the cycle in which o_wb_rf_we3 is high.

---
 rtl/riscv_core_wb_arb.sv | 173 +++++++++++++++++
 tb/tb_riscv_core_wb_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_wb_arb.sv
// Write-back arbiter sharing the register-file write port (we3/a3/wd3) among NUM_REQ producers.
// Optional fixed-priority-with-starvation-relief mode: define WB_ARB_FIXED_PRIO_EN.
module riscv_core_wb_arb #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                    i_wb_clk,
  input  logic                    i_wb_rst,
  input  logic                    i_wb_stall,
  input  logic [NUM_REQ-1:0]      i_wb_req_valid,
  input  logic [NUM_REQ*5-1:0]    i_wb_req_rd,
  input  logic [NUM_REQ*XLEN-1:0] i_wb_req_wd,
  output logic [NUM_REQ-1:0]      o_wb_req_ready,
  output logic                    o_wb_rf_we3,
  output logic [4:0]              o_wb_rf_a3,
  output logic [XLEN-1:0]         o_wb_rf_wd3,
  output logic [2:0]              o_wb_grant_id,
  output logic                    o_wb_busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned IDX_W = PTR_W + 1;
  localparam int unsigned RD_W  = 5;
  localparam int unsigned GID_W = 3;
  localparam int unsigned CNT_W = 3;

  // Reject parameter sets the grant-id and starvation-counter widths cannot represent.
  if (NUM_REQ < 2 || NUM_REQ > 8 || STARVE_LIMIT > 7) begin : g_param_check
    $error("riscv_core_wb_arb: NUM_REQ must be 2..8 and STARVE_LIMIT at most 7");
  end

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     rr_ptr_nxt;
  logic [NUM_REQ-1:0]   rr_valid;
  logic [2*NUM_REQ-1:0] rr_dbl;
  logic [NUM_REQ-1:0]   rr_rot;
  logic [PTR_W-1:0]     rr_off;
  logic [IDX_W-1:0]     rr_sum;
  logic                 rr_found;
  logic [PTR_W-1:0]     rr_win;

  logic                 grant_en;
  logic                 win_found;
  logic [PTR_W-1:0]     win;
  logic                 grant;
  logic [NUM_REQ-1:0]   ready_c;
  logic [RD_W-1:0]      sel_rd;
  logic [XLEN-1:0]      sel_wd;

`ifdef WB_ARB_FIXED_PRIO_EN
  logic                 upper_any;
  logic                 starved;
  logic [CNT_W-1:0]     starve_cnt;
  logic [CNT_W-1:0]     starve_cnt_nxt;
`endif

  assign grant_en = !i_wb_stall && !i_wb_rst;

  // Candidate set for the round-robin search; requester 0 leaves it in fixed-priority mode.
  always_comb begin
`ifdef WB_ARB_FIXED_PRIO_EN
    rr_valid  = i_wb_req_valid & ~NUM_REQ'(1);
    upper_any = |rr_valid;
`else
    rr_valid  = i_wb_req_valid;
`endif
  end

  // Rotate the request vector so the pointer sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rr_dbl   = {rr_valid, rr_valid};
    rr_rot   = NUM_REQ'(rr_dbl >> rr_ptr);
    rr_found = 1'b0;
    rr_off   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!rr_found && rr_rot[i]) begin
        rr_found = 1'b1;
        rr_off   = PTR_W'(i);
      end
    end
    rr_sum = IDX_W'(rr_ptr) + IDX_W'(rr_off);
    if (rr_sum >= IDX_W'(NUM_REQ)) begin
      rr_sum = rr_sum - IDX_W'(NUM_REQ);
    end
    rr_win = PTR_W'(rr_sum);
  end

  // Final winner selection, one-hot ready, payload mux and pointer update.
  always_comb begin
    win_found  = 1'b0;
    win        = '0;
    ready_c    = '0;
    sel_rd     = '0;
    sel_wd     = '0;
    rr_ptr_nxt = rr_ptr;
`ifdef WB_ARB_FIXED_PRIO_EN
    starved        = upper_any && (starve_cnt == CNT_W'(STARVE_LIMIT));
    starve_cnt_nxt = starve_cnt;
    if (i_wb_req_valid[0] && !starved) begin
      win_found = 1'b1;
      win       = '0;
    end else if (rr_found) begin
      win_found = 1'b1;
      win       = rr_win;
    end
`else
    win_found = rr_found;
    win       = rr_win;
`endif

    grant = win_found && grant_en;

    for (int k = 0; k < int'(NUM_REQ); k++) begin
      ready_c[k] = grant && (win == PTR_W'(k));
      if (ready_c[k]) begin
        sel_rd = i_wb_req_rd[RD_W*k +: RD_W];
        sel_wd = i_wb_req_wd[XLEN*k +: XLEN];
      end
    end

`ifdef WB_ARB_FIXED_PRIO_EN
    // Pointer only tracks requesters 1..NUM_REQ-1; a grant to 0 leaves it alone.
    if (grant && (win != '0)) begin
      rr_ptr_nxt = (win == PTR_W'(NUM_REQ - 1)) ? PTR_W'(1) : win + PTR_W'(1);
    end
    if (!upper_any) begin
      starve_cnt_nxt = '0;
    end else if (grant && (win != '0)) begin
      starve_cnt_nxt = '0;
    end else if (grant) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
`else
    if (grant) begin
      rr_ptr_nxt = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
    end
`endif
  end

  assign o_wb_req_ready = ready_c;
  assign o_wb_busy      = |(i_wb_req_valid & ~ready_c);

  // Registered RF write port; a3/wd3/grant_id hold between transfers, we3 pulses once per transfer.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      rr_ptr        <= '0;
      o_wb_rf_we3   <= 1'b0;
      o_wb_rf_a3    <= '0;
      o_wb_rf_wd3   <= '0;
      o_wb_grant_id <= '0;
    end else begin
      rr_ptr      <= rr_ptr_nxt;
      o_wb_rf_we3 <= grant && (sel_rd != '0);
      if (grant) begin
        o_wb_rf_a3    <= sel_rd;
        o_wb_rf_wd3   <= sel_wd;
        o_wb_grant_id <= GID_W'(win);
      end
    end
  end

`ifdef WB_ARB_FIXED_PRIO_EN
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_core_wb_arb.sv
// Bench for riscv_core_wb_arb (default round-robin build): directed table, reset corner, random vs model.
module tb_riscv_core_wb_arb;

  localparam int unsigned N  = 3;
  localparam int unsigned XL = 64;

  logic            clk;
  logic            rst;
  logic            stall;
  logic [N-1:0]    valid;
  logic [N*5-1:0]  rd;
  logic [N*XL-1:0] wd;
  logic [N-1:0]    ready;
  logic            we3;
  logic [4:0]      a3;
  logic [XL-1:0]   wd3;
  logic [2:0]      gid;
  logic            busy;

  riscv_core_wb_arb #(.NUM_REQ(N), .XLEN(XL), .STARVE_LIMIT(4)) dut (
    .i_wb_clk       (clk),
    .i_wb_rst       (rst),
    .i_wb_stall     (stall),
    .i_wb_req_valid (valid),
    .i_wb_req_rd    (rd),
    .i_wb_req_wd    (wd),
    .o_wb_req_ready (ready),
    .o_wb_rf_we3    (we3),
    .o_wb_rf_a3     (a3),
    .o_wb_rf_wd3    (wd3),
    .o_wb_grant_id  (gid),
    .o_wb_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [2:0]  valid;
    logic [14:0] rd;
    logic [63:0] wd_base;
    logic [2:0]  exp_ready;
    logic        exp_busy;
    logic        exp_we;
    logic [4:0]  exp_a3;
    logic [63:0] exp_wd;
    logic [2:0]  exp_gid;
  } vec_t;

  vec_t tbl[17];
  int   nvec;
  int   nmis;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester k presents wd = base + k.
  task automatic drive(input logic s, input logic [2:0] v, input logic [14:0] r, input logic [63:0] base);
    stall = s;
    valid = v;
    rd    = r;
    for (int k = 0; k < int'(N); k++) wd[64*k +: 64] = base + 64'(k);
  endtask

  function automatic vec_t mk(input logic s, input logic [2:0] v, input logic [14:0] r,
                              input logic [63:0] b, input logic [2:0] er, input logic eb,
                              input logic ew, input logic [4:0] ea, input logic [63:0] ed,
                              input logic [2:0] eg);
    vec_t t;
    t.stall = s; t.valid = v; t.rd = r; t.wd_base = b;
    t.exp_ready = er; t.exp_busy = eb; t.exp_we = ew;
    t.exp_a3 = ea; t.exp_wd = ed; t.exp_gid = eg;
    return t;
  endfunction

  // Random-phase requesters and reference model state.
  logic [2:0]  pend;
  logic [4:0]  prd[3];
  logic [63:0] pwd[3];
  int          mptr;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [63:0] m_wd;
  logic [2:0]  m_gid;
  int          win;
  int          kk;
  logic [2:0]  er;

  initial begin
    nvec = 0;
    nmis = 0;

    // Expected values derived by hand from the arbitration rules; pointer state carries row to row.
    tbl[0]  = mk(1'b0, 3'b001, {5'd0, 5'd0, 5'd5},  64'hDEAD_BEEF, 3'b001, 1'b0, 1'b1, 5'd5,  64'hDEAD_BEEF, 3'd0);
    tbl[1]  = mk(1'b0, 3'b100, {5'd7, 5'd0, 5'd0},  64'h100,       3'b100, 1'b0, 1'b1, 5'd7,  64'h102,       3'd2);
    tbl[2]  = mk(1'b0, 3'b111, {5'd3, 5'd2, 5'd1},  64'h200,       3'b001, 1'b1, 1'b1, 5'd1,  64'h200,       3'd0);
    tbl[3]  = mk(1'b0, 3'b111, {5'd3, 5'd2, 5'd1},  64'h200,       3'b010, 1'b1, 1'b1, 5'd2,  64'h201,       3'd1);
    tbl[4]  = mk(1'b0, 3'b111, {5'd3, 5'd2, 5'd1},  64'h200,       3'b100, 1'b1, 1'b1, 5'd3,  64'h202,       3'd2);
    tbl[5]  = mk(1'b0, 3'b111, {5'd3, 5'd2, 5'd1},  64'h200,       3'b001, 1'b1, 1'b1, 5'd1,  64'h200,       3'd0);
    tbl[6]  = mk(1'b0, 3'b111, {5'd3, 5'd2, 5'd1},  64'h200,       3'b010, 1'b1, 1'b1, 5'd2,  64'h201,       3'd1);
    tbl[7]  = mk(1'b0, 3'b111, {5'd3, 5'd2, 5'd1},  64'h200,       3'b100, 1'b1, 1'b1, 5'd3,  64'h202,       3'd2);
    tbl[8]  = mk(1'b1, 3'b110, {5'd10, 5'd9, 5'd0}, 64'h300,       3'b000, 1'b1, 1'b0, 5'd3,  64'h202,       3'd2);
    tbl[9]  = mk(1'b1, 3'b110, {5'd10, 5'd9, 5'd0}, 64'h300,       3'b000, 1'b1, 1'b0, 5'd3,  64'h202,       3'd2);
    tbl[10] = mk(1'b1, 3'b110, {5'd10, 5'd9, 5'd0}, 64'h300,       3'b000, 1'b1, 1'b0, 5'd3,  64'h202,       3'd2);
    tbl[11] = mk(1'b0, 3'b110, {5'd10, 5'd9, 5'd0}, 64'h300,       3'b010, 1'b1, 1'b1, 5'd9,  64'h301,       3'd1);
    tbl[12] = mk(1'b0, 3'b100, {5'd10, 5'd9, 5'd0}, 64'h300,       3'b100, 1'b0, 1'b1, 5'd10, 64'h302,       3'd2);
    tbl[13] = mk(1'b0, 3'b010, {5'd0, 5'd0, 5'd0},  64'h1233,      3'b010, 1'b0, 1'b0, 5'd0,  64'h1234,      3'd1);
    tbl[14] = mk(1'b0, 3'b011, {5'd0, 5'd6, 5'd4},  64'h400,       3'b001, 1'b1, 1'b1, 5'd4,  64'h400,       3'd0);
    tbl[15] = mk(1'b0, 3'b010, {5'd0, 5'd6, 5'd4},  64'h400,       3'b010, 1'b0, 1'b1, 5'd6,  64'h401,       3'd1);
    tbl[16] = mk(1'b0, 3'b000, {5'd0, 5'd6, 5'd4},  64'h400,       3'b000, 1'b0, 1'b0, 5'd6,  64'h401,       3'd1);

    // Reset state: ready forced low even with a valid request present.
    rst = 1'b1;
    drive(1'b0, 3'b001, 15'd0, 64'h0);
    #1;
    chk("rst ready", 64'(ready), 64'd0);
    chk("rst we3",   64'(we3),   64'd0);
    chk("rst a3",    64'(a3),    64'd0);
    chk("rst wd3",   wd3,        64'd0);
    chk("rst gid",   64'(gid),   64'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].stall, tbl[i].valid, tbl[i].rd, tbl[i].wd_base);
      #3;
      chk($sformatf("row%0d ready", i), 64'(ready), 64'(tbl[i].exp_ready));
      chk($sformatf("row%0d busy", i),  64'(busy),  64'(tbl[i].exp_busy));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d we3", i), 64'(we3), 64'(tbl[i].exp_we));
      chk($sformatf("row%0d a3", i),  64'(a3),  64'(tbl[i].exp_a3));
      chk($sformatf("row%0d wd3", i), wd3,      tbl[i].exp_wd);
      chk($sformatf("row%0d gid", i), 64'(gid), 64'(tbl[i].exp_gid));
    end

    // Reset right after a transfer: pending write dropped at once, pointer back to 0.
    drive(1'b0, 3'b010, {5'd0, 5'd11, 5'd0}, 64'h500);
    #3;
    chk("mid ready", 64'(ready), 64'b010);
    @(posedge clk);
    #1;
    chk("mid we3", 64'(we3), 64'd1);
    chk("mid a3",  64'(a3),  64'd11);
    rst = 1'b1;
    drive(1'b0, 3'b110, {5'd13, 5'd12, 5'd0}, 64'h500);
    #1;
    chk("mid rst we3",   64'(we3),   64'd0);
    chk("mid rst a3",    64'(a3),    64'd0);
    chk("mid rst wd3",   wd3,        64'd0);
    chk("mid rst gid",   64'(gid),   64'd0);
    chk("mid rst ready", 64'(ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post rst ready", 64'(ready), 64'b010);
    @(posedge clk);
    #1;
    chk("post rst we3", 64'(we3), 64'd1);
    chk("post rst a3",  64'(a3),  64'd12);
    chk("post rst wd3", wd3,      64'h501);
    chk("post rst gid", 64'(gid), 64'd1);

    // Randomized phase against the reference model.
    drive(1'b0, 3'b000, 15'd0, 64'h0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    pend  = 3'b000;
    mptr  = 0;
    m_we  = 1'b0;
    m_a3  = 5'd0;
    m_wd  = 64'd0;
    m_gid = 3'd0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (!pend[k] && $urandom_range(0, 99) < 60) begin
          pend[k] = 1'b1;
          prd[k]  = 5'($urandom_range(0, 31));
          pwd[k]  = {$urandom, $urandom};
        end
      end
      stall = ($urandom_range(0, 99) < 15);
      valid = pend;
      for (int k = 0; k < 3; k++) begin
        rd[5*k +: 5]   = prd[k];
        wd[64*k +: 64] = pwd[k];
      end
      win = -1;
      if (!stall) begin
        for (int i = 0; i < 3; i++) begin
          kk = (mptr + i) % 3;
          if (win < 0 && pend[kk]) win = kk;
        end
      end
      er = (win >= 0) ? 3'(1 << win) : 3'b000;
      #3;
      chk($sformatf("rnd%0d ready", c), 64'(ready), 64'(er));
      chk($sformatf("rnd%0d busy", c),  64'(busy),  64'(|(pend & ~er)));
      @(posedge clk);
      #1;
      if (win >= 0) begin
        m_we  = (prd[win] != 5'd0);
        m_a3  = prd[win];
        m_wd  = pwd[win];
        m_gid = 3'(win);
        mptr  = (win + 1) % 3;
        pend[win] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      chk($sformatf("rnd%0d we3", c), 64'(we3), 64'(m_we));
      chk($sformatf("rnd%0d a3", c),  64'(a3),  64'(m_a3));
      chk($sformatf("rnd%0d wd3", c), wd3,      m_wd);
      chk($sformatf("rnd%0d gid", c), 64'(gid), 64'(m_gid));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
